// File: rtl/fifo_pkg.sv
// Shared types and Gray/binary helpers for the async FIFO pointer path.
// Helpers work on a fixed maximum width; callers zero-extend and cast back.
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   typedef enum logic [0:0] {
      SYNC_FILL = 1'b0,
      SYNC_RUN  = 1'b1
   } sync_state_e;

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Clearing the lowest set bit leaves something only if two or more bits differ.
   function automatic logic multi_bit_change(input logic [PTR_MAX_W-1:0] a,
                                             input logic [PTR_MAX_W-1:0] b);
      logic [PTR_MAX_W-1:0] diff;
      diff = a ^ b;
      return (diff & (diff - 1'b1)) != '0;
   endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// Plain multi-flop synchronizer chain; the only logic that samples the foreign-domain bus.
// Timing constraints for the clock crossing target the stage register here.
module sync_stage_chain #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage <= {stage[STAGES-2:0], d};
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchronizer with binary conversion, advance count, post-reset fill
// tracking and Gray-integrity checking. One instance per side of the async FIFO.
module gray_ptr_sync
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                 dst_clk,
   input  logic                 dst_rst,
   input  logic [ADDR_SIZE:0]   src_ptr_gray,
   input  logic                 err_clr,
   output logic [ADDR_SIZE:0]   sync_ptr_gray,
   output logic [ADDR_SIZE:0]   sync_ptr_bin,
   output logic [ADDR_SIZE:0]   ptr_delta,
   output logic                 sync_valid,
   output logic                 gray_err,
   output logic [ERR_CNT_W-1:0] gray_err_cnt
);

   localparam int PTR_W  = ADDR_SIZE + 1;
   localparam int FILL_W = 3;

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || PTR_W > PTR_MAX_W) begin : g_bad_params
         $error("gray_ptr_sync: SYNC_STAGES must be 2..4 and ADDR_SIZE+1 <= %0d", PTR_MAX_W);
      end
   endgenerate

   sync_state_e       state;
   logic [FILL_W-1:0] fill_cnt;
   logic [PTR_W-1:0]  bin_next;
   logic              violation;
   logic              running;

   sync_stage_chain #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_chain (
      .clk (dst_clk),
      .rst (dst_rst),
      .d   (src_ptr_gray),
      .q   (sync_ptr_gray)
   );

   assign running    = (state == SYNC_RUN);
   assign sync_valid = running;
   assign bin_next   = PTR_W'(gray2bin(PTR_MAX_W'(sync_ptr_gray)));

   // sync_ptr_bin still holds the previous sample, so its Gray form is last cycle's sync_ptr_gray.
   assign violation  = running &&
                       multi_bit_change(PTR_MAX_W'(sync_ptr_gray),
                                        bin2gray(PTR_MAX_W'(sync_ptr_bin)));

   always_ff @(posedge dst_clk or posedge dst_rst) begin
      if (dst_rst) begin
         state    <= SYNC_FILL;
         fill_cnt <= '0;
      end else if (state == SYNC_FILL) begin
         fill_cnt <= fill_cnt + 1'b1;
         if (fill_cnt == FILL_W'(SYNC_STAGES)) begin
            state <= SYNC_RUN;
         end
      end
   end

   always_ff @(posedge dst_clk or posedge dst_rst) begin
      if (dst_rst) begin
         sync_ptr_bin <= '0;
         ptr_delta    <= '0;
      end else begin
         sync_ptr_bin <= bin_next;
         ptr_delta    <= running ? (bin_next - sync_ptr_bin) : '0;
      end
   end

   // A clear coinciding with a violation wipes history first, then records this violation.
   always_ff @(posedge dst_clk or posedge dst_rst) begin
      if (dst_rst) begin
         gray_err     <= 1'b0;
         gray_err_cnt <= '0;
      end else if (err_clr) begin
         gray_err     <= violation;
         gray_err_cnt <= violation ? ERR_CNT_W'(1) : '0;
      end else if (violation) begin
         gray_err <= 1'b1;
         if (gray_err_cnt != '1) begin
            gray_err_cnt <= gray_err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync: stimulus pushes per-edge expectations derived from the
// applied binary pointer history; a negedge monitor pops and compares every cycle.
module tb_gray_ptr_sync;

   localparam int A  = 4;
   localparam int S  = 3;
   localparam int EW = 2;
   localparam int PW = A + 1;
   localparam int CNT_MAX = (1 << EW) - 1;

   logic          clk;
   logic          rst;
   logic [PW-1:0] src_ptr_gray;
   logic          err_clr;
   logic [PW-1:0] sync_ptr_gray;
   logic [PW-1:0] sync_ptr_bin;
   logic [PW-1:0] ptr_delta;
   logic          sync_valid;
   logic          gray_err;
   logic [EW-1:0] gray_err_cnt;

   gray_ptr_sync #(
      .ADDR_SIZE   (A),
      .SYNC_STAGES (S),
      .ERR_CNT_W   (EW)
   ) dut (
      .dst_clk       (clk),
      .dst_rst       (rst),
      .src_ptr_gray  (src_ptr_gray),
      .err_clr       (err_clr),
      .sync_ptr_gray (sync_ptr_gray),
      .sync_ptr_bin  (sync_ptr_bin),
      .ptr_delta     (ptr_delta),
      .sync_valid    (sync_valid),
      .gray_err      (gray_err),
      .gray_err_cnt  (gray_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] g;
      logic [PW-1:0] b;
      logic [PW-1:0] d;
      logic          v;
      logic          e;
      int            c;
   } exp_t;

   exp_t          exp_q[$];
   int            total;
   int            passed;

   // Reference model: edges since reset release and the binary value applied at each edge.
   int            n;
   logic [PW-1:0] xsb[$];
   logic          m_err;
   int            m_cnt;

   function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Binary value visible on sync_ptr_gray (in Gray form) after edge k.
   function automatic logic [PW-1:0] xb_at(input int k);
      if (k >= S) return xsb[k-S];
      return '0;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, req, n, $time);
      end
   endtask

   task automatic model_edge(input logic [PW-1:0] b, input logic clr);
      exp_t e;
      logic viol;
      xsb.push_back(b);
      n++;
      e.g  = b2g(xb_at(n));
      e.b  = xb_at(n - 1);
      e.v  = (n >= S + 1);
      e.d  = (n >= S + 2) ? PW'(xb_at(n - 1) - xb_at(n - 2)) : '0;
      viol = (n >= S + 2) && ($countones(b2g(xb_at(n - 1)) ^ b2g(xb_at(n - 2))) > 1);
      if (clr) begin
         m_err = viol;
         m_cnt = viol ? 1 : 0;
      end else if (viol) begin
         m_err = 1'b1;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      e.e = m_err;
      e.c = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      n = 0;
      xsb.delete();
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   task automatic step(input logic [PW-1:0] b, input logic clr);
      src_ptr_gray = b2g(b);
      err_clr      = clr;
      @(posedge clk);
      model_edge(b, clr);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gray"},  int'(sync_ptr_gray), 0);
      chk({tag, "_bin"},   int'(sync_ptr_bin),  0);
      chk({tag, "_delta"}, int'(ptr_delta),     0);
      chk({tag, "_valid"}, int'(sync_valid),    0);
      chk({tag, "_err"},   int'(gray_err),      0);
      chk({tag, "_cnt"},   int'(gray_err_cnt),  0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sync_ptr_gray", int'(sync_ptr_gray), int'(e.g));
            chk("sync_ptr_bin",  int'(sync_ptr_bin),  int'(e.b));
            chk("ptr_delta",     int'(ptr_delta),     int'(e.d));
            chk("sync_valid",    int'(sync_valid),    int'(e.v));
            chk("gray_err",      int'(gray_err),      int'(e.e));
            chk("gray_err_cnt",  int'(gray_err_cnt),  e.c);
         end
      end
   end

   initial begin : stimulus
      logic [PW-1:0] cur;
      int r;
      total = 0;
      passed = 0;
      model_reset();
      rst = 1'b0;
      src_ptr_gray = '0;
      err_clr = 1'b0;
      #1 rst = 1'b1;
      #2 check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("reset released at t=%0t", $time);

      // Fill window and first-sample latency.
      repeat (8) step('0, 1'b0);
      cur = 5'd1;
      repeat (6) step(cur, 1'b0);

      // Legal counting with random dwell, then the 30,31,0,1 wrap at 4 cycles per step.
      while (cur != 5'd29) begin
         cur = cur + 1'b1;
         repeat ($urandom_range(1, 3)) step(cur, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         cur = PW'(30 + i);
         repeat (4) step(cur, 1'b0);
      end
      $display("wrap sequence done, pointer=%0d", cur);

      // Two-bit jumps between 1 and 31 until the counter saturates.
      for (int i = 0; i < 6; i++) begin
         cur = (i % 2 == 0) ? 5'd31 : 5'd1;
         repeat (4) step(cur, 1'b0);
      end

      // Clear in the very edge that detects a new violation (1 -> 31).
      cur = 5'd31;
      repeat (S) step(cur, 1'b0);
      step(cur, 1'b1);
      repeat (4) step(cur, 1'b0);
      step(cur, 1'b1);
      repeat (2) step(cur, 1'b0);
      $display("clear sequence done");

      // Randomised mix of holds, legal steps, arbitrary jumps and clears.
      repeat (300) begin
         r = int'($urandom_range(0, 99));
         if (r < 10) cur = PW'($urandom_range(0, 31));
         else if (r < 60) cur = cur + 1'b1;
         step(cur, $urandom_range(0, 19) == 0);
      end

      // Settle on 9, then reset mid-run with no clock edge in between.
      while (cur != 5'd9) begin
         cur = cur + 1'b1;
         step(cur, 1'b0);
      end
      repeat (S + 2) step(cur, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_all_zero("midreset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) step(cur, 1'b0);

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
